// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared UART definitions (transmitter and receiver): one-hot
//               state encoding, parity mode constants, ticks per bit.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

   localparam int TICKS_PER_BIT = 16;

   localparam int PARITY_NONE = 0;
   localparam int PARITY_EVEN = 1;
   localparam int PARITY_ODD  = 2;

   localparam logic [4:0] ST_IDLE   = 5'b00001;
   localparam logic [4:0] ST_START  = 5'b00010;
   localparam logic [4:0] ST_DATA   = 5'b00100;
   localparam logic [4:0] ST_PARITY = 5'b01000;
   localparam logic [4:0] ST_STOP   = 5'b10000;

   typedef enum logic [4:0] {
      S_IDLE   = ST_IDLE,
      S_START  = ST_START,
      S_DATA   = ST_DATA,
      S_PARITY = ST_PARITY,
      S_STOP   = ST_STOP
   } state_e;

endpackage
`default_nettype wire

// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx
// Description : UART transmitter. Serialises one word per valid/ready
//               handshake, LSB first: start, data, optional parity, stop.
//               Bit timing is driven by an external 16x baud tick.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx
   import uart_pkg::*;
#(
   parameter int NB_DATA = 8,
   parameter int SB_TICK = 16,
   parameter int PARITY  = 0
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_tick,
   input  logic [NB_DATA-1:0] i_data,
   input  logic               i_valid,
   output logic               o_ready,
   output logic               o_tx,
   output logic               o_done
);

   localparam int                 NB_BCNT     = $clog2(NB_DATA + 1);
   localparam logic [4:0]         C_LAST_TICK = 5'(TICKS_PER_BIT - 1);
   localparam logic [4:0]         C_STOP_LAST = 5'(SB_TICK - 1);
   localparam logic [NB_BCNT-1:0] C_LAST_BIT  = NB_BCNT'(NB_DATA - 1);
   localparam logic               C_ODD       = (PARITY == PARITY_ODD);
   localparam logic               C_HAS_PAR   = (PARITY != PARITY_NONE);

   state_e               state_q, state_d;
   logic [4:0]           tick_q,  tick_d;
   logic [NB_BCNT-1:0]   bit_q,   bit_d;
   logic [NB_DATA-1:0]   shreg_q, shreg_d;
   logic [NB_DATA-1:0]   word_q,  word_d;
   logic                 tx_q,    tx_d;
   logic                 done_q,  done_d;
   logic                 par_bit;

   // Next-state logic for the frame sequencer, counters, shifter and line
   always_comb begin
      state_d = state_q;
      tick_d  = tick_q;
      bit_d   = bit_q;
      shreg_d = shreg_q;
      word_d  = word_q;
      done_d  = 1'b0;
      // Parity comes from the latched copy so i_data may change mid-frame
      par_bit = (^word_q) ^ C_ODD;

      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               shreg_d = i_data;
               word_d  = i_data;
               tick_d  = 5'd0;
               bit_d   = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (i_tick) begin
               if (tick_q == C_LAST_TICK) begin
                  tick_d  = 5'd0;
                  state_d = S_DATA;
               end else begin
                  tick_d = tick_q + 5'd1;
               end
            end
         end
         S_DATA: begin
            if (i_tick) begin
               if (tick_q == C_LAST_TICK) begin
                  tick_d  = 5'd0;
                  shreg_d = shreg_q >> 1;
                  bit_d   = bit_q + NB_BCNT'(1);
                  if (bit_q == C_LAST_BIT) begin
                     state_d = C_HAS_PAR ? S_PARITY : S_STOP;
                  end
               end else begin
                  tick_d = tick_q + 5'd1;
               end
            end
         end
         S_PARITY: begin
            if (i_tick) begin
               if (tick_q == C_LAST_TICK) begin
                  tick_d  = 5'd0;
                  state_d = S_STOP;
               end else begin
                  tick_d = tick_q + 5'd1;
               end
            end
         end
         S_STOP: begin
            if (i_tick) begin
               if (tick_q == C_STOP_LAST) begin
                  tick_d  = 5'd0;
                  done_d  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  tick_d = tick_q + 5'd1;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Line level follows the state being entered so o_tx can be registered
      unique case (state_d)
         S_START:  tx_d = 1'b0;
         S_DATA:   tx_d = shreg_d[0];
         S_PARITY: tx_d = par_bit;
         default:  tx_d = 1'b1;
      endcase
   end

   // State, counters, shift register and registered line output
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         tick_q  <= 5'd0;
         bit_q   <= '0;
         shreg_q <= '0;
         word_q  <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         tick_q  <= tick_d;
         bit_q   <= bit_d;
         shreg_q <= shreg_d;
         word_q  <= word_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
      end
   end

   assign o_ready = (state_q == S_IDLE);
   assign o_tx    = tx_q;
   assign o_done  = done_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_tx
// Description : Self-checking bench for uart_tx. Four instances cover no
//               parity, even parity, odd parity and a 2-stop-bit period.
//               Sent words go into a scoreboard queue; a tick-accurate frame
//               decoder pops and compares them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

   logic       r_clk;
   logic       r_rst_n;
   logic       r_tick;
   logic [3:0] r_valid;
   logic [7:0] r_data [4];
   wire  [3:0] w_tx;
   wire  [3:0] w_rdy;
   wire  [3:0] w_done;

   int         n_tests = 0;
   int         n_fail  = 0;
   int         done_cnt [4] = '{default: 0};
   int         tcnt    = 0;
   logic [7:0] sb_q [$];

   uart_tx #(.NB_DATA(8), .SB_TICK(16), .PARITY(0)) u_dut0 (
      .i_clk(r_clk), .i_reset_n(r_rst_n), .i_tick(r_tick), .i_data(r_data[0]),
      .i_valid(r_valid[0]), .o_ready(w_rdy[0]), .o_tx(w_tx[0]), .o_done(w_done[0]));
   uart_tx #(.NB_DATA(8), .SB_TICK(16), .PARITY(1)) u_dut1 (
      .i_clk(r_clk), .i_reset_n(r_rst_n), .i_tick(r_tick), .i_data(r_data[1]),
      .i_valid(r_valid[1]), .o_ready(w_rdy[1]), .o_tx(w_tx[1]), .o_done(w_done[1]));
   uart_tx #(.NB_DATA(8), .SB_TICK(16), .PARITY(2)) u_dut2 (
      .i_clk(r_clk), .i_reset_n(r_rst_n), .i_tick(r_tick), .i_data(r_data[2]),
      .i_valid(r_valid[2]), .o_ready(w_rdy[2]), .o_tx(w_tx[2]), .o_done(w_done[2]));
   uart_tx #(.NB_DATA(8), .SB_TICK(32), .PARITY(0)) u_dut3 (
      .i_clk(r_clk), .i_reset_n(r_rst_n), .i_tick(r_tick), .i_data(r_data[3]),
      .i_valid(r_valid[3]), .o_ready(w_rdy[3]), .o_tx(w_tx[3]), .o_done(w_done[3]));

   // 100 MHz-style clock
   initial begin
      r_clk = 1'b0;
      forever #5 r_clk = ~r_clk;
   end

   // Baud tick: one cycle high every 4 clocks
   initial begin
      r_tick = 1'b0;
      forever begin
         @(posedge r_clk);
         #1;
         tcnt   = tcnt + 1;
         r_tick = ((tcnt % 4) == 0);
      end
   end

   // Count o_done pulses per instance
   always @(posedge r_clk) begin
      for (int k = 0; k < 4; k++) begin
         if (w_done[k]) done_cnt[k] <= done_cnt[k] + 1;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Present a word and wait for the handshake edge; word enters the scoreboard
   task automatic send(input int s, input logic [7:0] d, input bit hold);
      int c;
      c = 0;
      @(negedge r_clk);
      r_valid[s] = 1'b1;
      r_data[s]  = d;
      while (!w_rdy[s] && c < 2000) begin
         @(negedge r_clk);
         c++;
      end
      chk("handshake_ready", 32'(w_rdy[s]), 32'd1);
      @(posedge r_clk);
      sb_q.push_back(d);
      #1;
      if (!hold) r_valid[s] = 1'b0;
      r_data[s] = ~d;
   endtask

   // Follow one frame tick by tick from the handshake edge; ends on the
   // negedge of the o_done cycle
   task automatic check_frame(input int s, input int par, input int sb);
      logic [7:0] exp_w;
      logic [7:0] got;
      logic       eb;
      int         nb, total, n, c, k;
      exp_w = sb_q.pop_front();
      nb    = 9 + ((par != 0) ? 1 : 0);
      total = 16 * nb + sb;
      got   = 8'h00;
      n     = 0;
      c     = 0;
      while (n < total && c < 4 * total + 64) begin
         @(negedge r_clk);
         c++;
         if (r_tick) begin
            k = n / 16;
            if (k == 0)       eb = 1'b0;
            else if (k <= 8)  eb = exp_w[k-1];
            else if (k < nb)  eb = (^exp_w) ^ (par == 2);
            else              eb = 1'b1;
            chk($sformatf("line_dut%0d_tick%0d", s, n), 32'(w_tx[s]), 32'(eb));
            chk($sformatf("done_early_dut%0d_tick%0d", s, n), 32'(w_done[s]), 32'd0);
            if ((n % 16) == 8 && k >= 1 && k <= 8) got[k-1] = w_tx[s];
            n++;
         end
      end
      chk($sformatf("frame_ticks_dut%0d", s), n, total);
      @(negedge r_clk);
      chk($sformatf("done_dut%0d", s), 32'(w_done[s]), 32'd1);
      chk($sformatf("ready_at_done_dut%0d", s), 32'(w_rdy[s]), 32'd1);
      chk($sformatf("rx_word_dut%0d", s), 32'(got), 32'(exp_w));
   endtask

   initial begin
      int d0;
      int n;
      int c;
      int hi;
      logic [7:0] junk;

      r_rst_n = 1'b0;
      r_valid = 4'b0000;
      for (int i = 0; i < 4; i++) r_data[i] = 8'h00;
      repeat (3) @(negedge r_clk);
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("reset_tx_dut%0d", i), 32'(w_tx[i]), 32'd1);
         chk($sformatf("reset_ready_dut%0d", i), 32'(w_rdy[i]), 32'd1);
         chk($sformatf("reset_done_dut%0d", i), 32'(w_done[i]), 32'd0);
      end
      r_rst_n = 1'b1;
      repeat (10) @(negedge r_clk);

      // Basic frame, no parity, one o_done pulse
      d0 = done_cnt[0];
      send(0, 8'h55, 1'b0);
      check_frame(0, 0, 16);
      @(posedge r_clk); #1;
      chk("done_count_0x55", done_cnt[0] - d0, 1);

      // Parity variants
      send(1, 8'h07, 1'b0);
      check_frame(1, 1, 16);
      send(2, 8'h07, 1'b0);
      check_frame(2, 2, 16);
      send(1, 8'h00, 1'b0);
      check_frame(1, 1, 16);

      // Back-to-back frames with i_valid held high
      d0 = done_cnt[0];
      send(0, 8'hA3, 1'b1);
      r_data[0] = 8'h3C;
      check_frame(0, 0, 16);
      @(posedge r_clk);
      sb_q.push_back(8'h3C);
      #1;
      r_valid[0] = 1'b0;
      r_data[0]  = 8'h00;
      check_frame(0, 0, 16);
      @(posedge r_clk); #1;
      chk("done_count_b2b", done_cnt[0] - d0, 2);

      // Request while busy is ignored
      d0 = done_cnt[0];
      send(0, 8'h96, 1'b0);
      fork
         check_frame(0, 0, 16);
         begin
            repeat (200) @(negedge r_clk);
            r_valid[0] = 1'b1;
            r_data[0]  = 8'hFF;
            @(negedge r_clk);
            r_valid[0] = 1'b0;
         end
      join
      hi = 0;
      for (int i = 0; i < 80; i++) begin
         @(negedge r_clk);
         if (w_tx[0] === 1'b1 && w_rdy[0] === 1'b1) hi++;
      end
      chk("idle_after_ignored_req", hi, 80);
      chk("done_count_ignored", done_cnt[0] - d0, 1);

      // Asynchronous reset during data bit 3
      d0 = done_cnt[0];
      send(0, 8'hF0, 1'b0);
      n = 0;
      c = 0;
      while (n < 73 && c < 1000) begin
         @(negedge r_clk);
         c++;
         if (r_tick) n++;
      end
      chk("reached_data_bit3", n, 73);
      chk("tx_bit3_before_reset", 32'(w_tx[0]), 32'd0);
      #1;
      r_rst_n = 1'b0;
      #1;
      chk("async_reset_tx", 32'(w_tx[0]), 32'd1);
      chk("async_reset_ready", 32'(w_rdy[0]), 32'd1);
      chk("async_reset_done", 32'(w_done[0]), 32'd0);
      repeat (3) @(negedge r_clk);
      r_rst_n = 1'b1;
      junk = sb_q.pop_front();
      repeat (4) @(negedge r_clk);
      chk("no_done_after_abort", done_cnt[0] - d0, 0);
      chk("abandoned_word", 32'(junk), 32'hF0);
      send(0, 8'h81, 1'b0);
      check_frame(0, 0, 16);

      // Two stop bits
      send(3, 8'h5A, 1'b0);
      check_frame(3, 0, 32);

      repeat (10) @(negedge r_clk);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/uart_tx.md
# uart_tx

- Serial UART transmitter; the sending end of the link whose receiver samples on a 16x oversampling tick.
- Accepts one parallel word per valid/ready handshake and serialises it LSB-first on `o_tx`: start bit, NB_DATA data bits, optional parity bit, stop period.
- Sits between the application/ALU result path and the TX pin; shares the baud-rate generator's `i_tick` with the receiver.

## Interface
- `NB_DATA`, 8: data bits per frame.
- `SB_TICK`, 16: ticks in the stop period. Legal values: 16 (1 stop bit), 24 (1.5), 32 (2).
- `PARITY`, 0: parity mode. 0 = none, 1 = even, 2 = odd.
- `i_clk` in 1: system clock, all logic on rising edge.
- `i_reset_n` in 1: reset, asynchronous, active-low.
- `i_tick` in 1: one-cycle baud tick pulse, 16 per bit period.
- `i_data` in NB_DATA: word to send, sampled at handshake.
- `i_valid` in 1: request to send `i_data`.
- `o_ready` out 1: high when idle and able to accept a word.
- `o_tx` out 1: serial line; idles high.
- `o_done` out 1: one-cycle pulse at end of stop period.

## Operation
- States: IDLE, START, DATA, PARITY, STOP. Encoding constants come from the shared package.
- **IDLE**
  - `o_tx`=1, `o_ready`=1.
  - On `i_valid & o_ready`: latch `i_data` into the shift register, clear tick and bit counters, go to START.
- **START**
  - `o_tx`=0.
  - Count ticks. On the tick with count==15, go to DATA and clear the count.
- **DATA**
  - `o_tx` = shift register LSB.
  - On the tick with count==15: shift right and increment the bit counter.
  - After bit NB_DATA-1: go to PARITY if `PARITY`!=0, else STOP.
- **PARITY**
  - `o_tx` = XOR-reduce of the latched word; inverted when `PARITY`==2.
  - Lasts 16 ticks, then STOP.
- **STOP**
  - `o_tx`=1.
  - On the tick with count==SB_TICK-1: assert `o_done`, go to IDLE.
- Counter widths:
  - Tick counter is 5 bits; it wraps only by the explicit clear at each state exit.
  - Bit counter is `$clog2(NB_DATA+1)` bits.
- Ticks arriving in IDLE are ignored. The tick counter only advances when `i_tick`=1.
- Parity is computed from the latched copy, never from live `i_data`.
- `i_valid` while `o_ready`=0 is ignored; there is no queue. The source must hold `i_valid` until it sees `o_ready`.
- `i_data` may change freely after the handshake cycle.

## Timing
- Reset values: `o_tx`=1, `o_ready`=1, `o_done`=0, state IDLE, counters 0.
- Reset is asynchronous. Asserting it mid-frame immediately forces the line high and abandons the frame; no `o_done` is issued.
- `o_tx` is registered.
- Handshake and start bit:
  - The start bit appears on the rising edge after the handshake cycle.
  - `o_ready` falls on the same edge.
- The first data bit begins on the clock after the 16th tick counted in START.
- Every bit, including parity, spans exactly 16 ticks.
- Frame length in ticks: 16·(1+NB_DATA+P) + SB_TICK, where P=1 if parity is enabled.
- `o_done` and the `o_ready` rise are asserted in the same cycle, immediately after the final stop tick.
- Back-to-back frames:
  - An `i_valid` held high during that cycle is accepted.
  - The next start bit then follows with zero idle ticks.
- `i_tick` coinciding with the handshake cycle is not counted toward the start bit.

## Structure
- Shared package `uart_pkg` (shared with the receiver) holds:
  - state encoding localparams (one-hot, 5 bits);
  - `PARITY_NONE/EVEN/ODD` constants;
  - `TICKS_PER_BIT`=16.
- No sub-module. Parity is an inline reduction XOR and the baud generator lives outside.
- Implementation structure:
  - one sequential block for state, counters, shift register and `o_tx`;
  - one combinational next-state block.

## Test plan
- Reset, NB_DATA=8, PARITY=0, SB_TICK=16, tick every 4 clocks, send 0x55 → `o_tx` sequence 0,1,0,1,0,1,0,1,0,1, each held 16 ticks. `o_done` pulses once, 160 ticks after start.
- PARITY=1 send 0x07 → parity bit 1; PARITY=2 send 0x07 → parity bit 0; PARITY=1 send 0x00 → parity bit 0.
- Hold `i_valid` high with 0xA3 then 0x3C → two frames with no idle gap; exactly 2 `o_done` pulses; loopback into the receiver yields 0xA3, 0x3C.
- Pulse `i_valid` with 0xFF while `o_ready`=0 mid-frame → ignored; the current frame completes unchanged and the line stays high afterwards.
- Assert `i_reset_n`=0 during data bit 3 → `o_tx`=1 and `o_ready`=1 asynchronously, no `o_done`. The next request 0x81 transmits correctly.
- SB_TICK=32 → stop period is exactly 32 ticks high before `o_done`.
